// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential unsigned multiplier:
//   state_t      - FSM states (IDLE / RUN / DONE)
//   DEF_WIDTH    - default operand width
//   DEF_CNT_W    - iteration counter width for the default operand width
//   cnt_width()  - iteration counter width for an arbitrary operand width
// -----------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mult_u_step.sv
// -----------------------------------------------------------------------------
// mult_u_step
// One radix-2 shift-add iteration of an unsigned multiply (combinational).
// Ports:
//   acc      [WIDTH-1:0] in  : upper half of the working product
//   mq       [WIDTH-1:0] in  : lower half (unconsumed multiplier bits)
//   mcand    [WIDTH-1:0] in  : multiplicand
//   acc_nxt  [WIDTH-1:0] out : upper half after add-and-shift
//   mq_nxt   [WIDTH-1:0] out : lower half after add-and-shift
// -----------------------------------------------------------------------------
module mult_u_step
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] mq_nxt
);

  logic [WIDTH:0] w_addend;
  logic [WIDTH:0] w_sum;

  // The add is WIDTH+1 bits wide so the carry survives; it becomes the new
  // MSB of acc after the right shift.
  always_comb begin
    w_addend = mq[0] ? {1'b0, mcand} : '0;
    w_sum    = {1'b0, acc} + w_addend;
  end

  // {sum, mq} >> 1: sum[0] drops into the top of mq, mq[0] is consumed.
  assign acc_nxt = w_sum[WIDTH:1];
  assign mq_nxt  = {w_sum[0], mq[WIDTH-1:1]};

endmodule

// File: rtl/mult_u_seq.sv
// -----------------------------------------------------------------------------
// mult_u_seq
// Sequential unsigned multiplier, one multiplier bit per clock, producing the
// full 2*WIDTH product as HI/LO words behind a start/busy/done handshake.
// Ports:
//   clk          in  : rising-edge clock
//   reset        in  : asynchronous active-high reset
//   start        in  : request a multiply (sampled only in IDLE)
//   multiplicand in  : operand A [WIDTH-1:0], captured on the accepting edge
//   multiplier   in  : operand B [WIDTH-1:0], captured on the accepting edge
//   busy         out : high while iterating
//   done         out : one-cycle pulse after the product registers update
//   productHI    out : upper WIDTH bits of A*B (held until the next result)
//   productLO    out : lower WIDTH bits of A*B (held until the next result)
// -----------------------------------------------------------------------------
module mult_u_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] productHI,
  output logic [WIDTH-1:0] productLO
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mq;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_prod_hi;
  logic [WIDTH-1:0]   r_prod_lo;

  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_mq_nxt;
  logic               w_accept;
  logic               w_last_iter;

  mult_u_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc     (r_acc),
    .mq      (r_mq),
    .mcand   (r_mcand),
    .acc_nxt (w_acc_nxt),
    .mq_nxt  (w_mq_nxt)
  );

  assign w_accept    = (r_state == IDLE) && start;
  // count is pre-increment, so WIDTH-1 marks the WIDTH-th iteration.
  assign w_last_iter = (r_state == RUN) && (r_count == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start)       w_state_nxt = RUN;
      RUN:     if (w_last_iter) w_state_nxt = DONE;
      DONE:                     w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // Working registers: loaded on acceptance, advanced once per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_mcand <= multiplicand;
      r_acc   <= '0;
      r_mq    <= multiplier;
      r_count <= '0;
    end else if (r_state == RUN) begin
      r_acc   <= w_acc_nxt;
      r_mq    <= w_mq_nxt;
      r_count <= r_count + 1'b1;
    end
  end

  // Result registers take the post-shift value only on the final iteration,
  // so partial products never reach the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prod_hi <= '0;
      r_prod_lo <= '0;
    end else if (w_last_iter) begin
      r_prod_hi <= w_acc_nxt;
      r_prod_lo <= w_mq_nxt;
    end
  end

  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign productHI = r_prod_hi;
  assign productLO = r_prod_lo;

endmodule

// File: tb/tb_mult_u_seq.sv
// -----------------------------------------------------------------------------
// tb_mult_u_seq
// Self-checking bench for mult_u_seq (WIDTH=32): table-driven vectors plus
// hand-written sequences, with a scoreboard queue of expected products.
// -----------------------------------------------------------------------------
module tb_mult_u_seq;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic          busy;
  logic          done;
  logic [W-1:0]  productHI;
  logic [W-1:0]  productLO;

  int n_checks   = 0;
  int n_failures = 0;

  logic [2*W-1:0] sb_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[8];

  mult_u_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .productHI    (productHI),
    .productLO    (productLO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse, flags done with nothing
  // expected, busy/done overlap, and products changing without done.
  logic [2*W-1:0] prev_prod = '0;
  always @(negedge clk) begin
    logic [2*W-1:0] exp_p;
    check("busy_done_overlap", {63'd0, busy & done}, 64'd0);
    if (reset) begin
      prev_prod = {productHI, productLO};
    end else begin
      if ({productHI, productLO} !== prev_prod)
        check("product_change_without_done", {63'd0, done}, 64'd1);
      prev_prod = {productHI, productLO};
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_p = sb_q.pop_front();
          check("productHI", {32'd0, productHI}, {32'd0, exp_p[2*W-1:W]});
          check("productLO", {32'd0, productLO}, {32'd0, exp_p[W-1:0]});
        end
      end
    end
  end

  // Full operation: pulse start, count busy cycles, check a single done pulse.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hi, input logic [W-1:0] lo);
    int n_busy;
    int cyc;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    sb_q.push_back({hi, lo});
    @(negedge clk);
    start = 1'b0;
    n_busy = 0;
    cyc    = 0;
    while (!done && cyc < 200) begin
      if (busy) n_busy++;
      cyc++;
      @(negedge clk);
    end
    check("done_timeout", {63'd0, done}, 64'd1);
    check("busy_cycles", 64'(n_busy), 64'd32);
    @(negedge clk);
    check("done_single_pulse", {63'd0, done}, 64'd0);
    check("idle_after_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int k;
    int acc_edge;
    logic prev_busy;

    vecs[0] = '{32'd34,        32'd5,          32'h0000_0000, 32'd170};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{32'h8000_0000, 32'd2,          32'h0000_0001, 32'h0000_0000};
    vecs[3] = '{32'd0,         32'hDEAD_BEEF,  32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE};
    vecs[5] = '{32'h0001_0000, 32'h0001_0000,  32'h0000_0001, 32'h0000_0000};
    vecs[6] = '{32'd1,         32'hFFFF_FFFF,  32'h0000_0000, 32'hFFFF_FFFF};
    vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0010,  32'h0000_000F, 32'hFFFF_FFF0};

    reset = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", {32'd0, productHI}, 64'd0);
    check("reset_lo", {32'd0, productLO}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // start and operand changes during RUN and DONE must be ignored
    @(negedge clk);
    multiplicand = 32'd34;
    multiplier   = 32'd5;
    start        = 1'b1;
    sb_q.push_back({32'd0, 32'd170});
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    multiplicand = 32'd1000;
    multiplier   = 32'd1000;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    multiplicand = 32'd77;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("ign_done_seen", {63'd0, done}, 64'd1);
    start = 1'b1;
    multiplier = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (6) begin
      check("ign_no_restart_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
    end
    check("ign_hi_held", {32'd0, productHI}, 64'd0);
    check("ign_lo_held", {32'd0, productLO}, 64'd170);

    // reset mid-operation
    @(negedge clk);
    multiplicand = 32'd7;
    multiplier   = 32'd9;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_done", {63'd0, done}, 64'd0);
    check("rst_mid_hi", {32'd0, productHI}, 64'd0);
    check("rst_mid_lo", {32'd0, productLO}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_abort_no_result", {32'd0, productLO}, 64'd0);
    run_op(32'd3, 32'd4, 32'd0, 32'd12);

    // back-to-back with start held high
    @(negedge clk);
    multiplicand = 32'd6;
    multiplier   = 32'd7;
    start        = 1'b1;
    sb_q.push_back({32'd0, 32'd42});
    sb_q.push_back({32'd0, 32'd10000});
    @(negedge clk);
    multiplicand = 32'd100;
    multiplier   = 32'd100;
    prev_busy = busy;
    acc_edge  = -1;
    for (int e = 1; e < 80 && acc_edge < 0; e++) begin
      @(negedge clk);
      if (busy && !prev_busy) acc_edge = e;
      prev_busy = busy;
    end
    start = 1'b0;
    check("b2b_second_accept_edge", 64'(acc_edge), 64'd34);
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("b2b_done_seen", {63'd0, done}, 64'd1);
    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
